// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Size codes, FSM states and the captured-request bundle.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and lane select/extension for loads.
// Also flags misaligned accesses and the illegal size code.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic        is_unsigned,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] shifted;

  assign shifted = rword >> {offset, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata      = '0;
    err        = 1'b0;
    case (size)
      SIZE_B: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
        rdata      = is_unsigned ? {24'b0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        err        = offset[0];
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata      = is_unsigned ? {16'b0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_W: begin
        err        = (offset != 2'b00);
        be         = 4'b1111;
        rdata      = rword;
      end
      default: begin
        err        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES wait cycles.
// Define DMEM_MMIO_EN to map a free-running cycle counter at MMIO_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_ADDR   = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  req_t                  req_q;
  logic                  accept;

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;

  logic [3:0]            be;
  logic [31:0]           wlane;
  logic [31:0]           ld_data;
  logic                  align_err;

  logic                  acc_err;
  logic [31:0]           rdata_nxt;

  assign req_ready_o = (state == ST_IDLE) && !rst;
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= WAIT_CNT_W'(WAIT_STATES);
        req_q <= '{we:    req_we_i,
                   addr:  req_addr_i,
                   wdata: req_wdata_i,
                   size:  req_size_i,
                   uns:   req_unsigned_i};
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        if (cnt == WAIT_CNT_W'(1))
          state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign widx     = req_q.addr[ADDR_WIDTH+1:2];
  assign in_range = (req_q.addr[31:ADDR_WIDTH+2] == '0);

  dmem_lane_align u_align (
    .size        (req_q.size),
    .offset      (req_q.addr[1:0]),
    .wdata       (req_q.wdata),
    .is_unsigned (req_q.uns),
    .rword       (mem[widx]),
    .be          (be),
    .wdata_lane  (wlane),
    .rdata       (ld_data),
    .err         (align_err)
  );

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_cnt;
  logic        mmio_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_cnt <= '0;
    else     cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign mmio_hit = (req_q.addr == MMIO_ADDR);

  // The counter address overrides normal decode, even if it is in range.
  always_comb begin
    acc_err   = align_err || !in_range;
    rdata_nxt = ld_data;
    if (mmio_hit) begin
      acc_err   = req_q.we || (req_q.size != SIZE_W);
      rdata_nxt = cyc_cnt;
    end
    if (acc_err || req_q.we)
      rdata_nxt = '0;
  end
`else
  logic unused_mmio;

  assign unused_mmio = ^MMIO_ADDR;

  always_comb begin
    acc_err   = align_err || !in_range;
    rdata_nxt = ld_data;
    if (acc_err || req_q.we)
      rdata_nxt = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && req_q.we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= (state == ST_ACCESS);
      rsp_rdata_o <= (state == ST_ACCESS) ? rdata_nxt : '0;
      rsp_err_o   <= (state == ST_ACCESS) && acc_err;
    end
  end

endmodule
